replay_buffer_ctrl: RTL

REPLAY_BUFFER_CTRL -- requirements
Module: replay_buffer_ctrl

---
 rtl/replay_buffer_ctrl.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/replay_buffer_ctrl.sv
// Experience-replay buffer: circular transition store with direct or LFSR-random sampling.
// Optional random sampling (LFSR + SEARCH state) is enabled by defining REPLAY_RANDOM_SAMPLE_EN.
module replay_buffer_ctrl #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned STATE_NUM    = 2,
    parameter int unsigned ACTION_WIDTH = 2,
    parameter int unsigned DEPTH        = 10000,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1,
    localparam int unsigned ADDR_W      = $clog2(DEPTH + 1)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            i_wr_valid,
    input  logic [STATE_NUM*DATA_WIDTH-1:0] i_current_state,
    input  logic [ACTION_WIDTH-1:0]         i_action,
    input  logic [DATA_WIDTH-1:0]           i_reward,
    input  logic [STATE_NUM*DATA_WIDTH-1:0] i_next_state,
    input  logic                            i_done,
    input  logic                            i_rd_valid,
    input  logic                            i_rd_random,
    input  logic [ADDR_W-1:0]               i_rd_addr,
    output logic                            o_rd_ready,
    output logic                            o_valid,
    output logic [STATE_NUM*DATA_WIDTH-1:0] o_current_state,
    output logic [ACTION_WIDTH-1:0]         o_action,
    output logic [DATA_WIDTH-1:0]           o_reward,
    output logic [STATE_NUM*DATA_WIDTH-1:0] o_next_state,
    output logic                            o_done,
    output logic                            o_rd_err,
    output logic [ADDR_W-1:0]               o_count,
    output logic                            o_full,
    output logic                            o_empty
);

    localparam int unsigned SW     = STATE_NUM * DATA_WIDTH;
    localparam int unsigned MEM_AW = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);

`ifdef REPLAY_RANDOM_SAMPLE_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SEARCH = 2'd1, READ = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd2} state_t;
`endif

    state_t state_q, state_d;

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              rd_ready_q, rd_ready_d;
    logic              valid_q, valid_d;
    logic              rd_err_q, rd_err_d;
    logic [SW-1:0]           cs_q, cs_d;
    logic [ACTION_WIDTH-1:0] act_q, act_d;
    logic [DATA_WIDTH-1:0]   rew_q, rew_d;
    logic [SW-1:0]           ns_q, ns_d;
    logic                    done_q, done_d;

    logic              wr_en_c;
    logic              rd_en_c;
    logic [ADDR_W-1:0] rd_addr_c;

    // Per-field storage, one write port and one synchronous read port each
    logic [SW-1:0]           mem_cs   [DEPTH];
    logic [ACTION_WIDTH-1:0] mem_act  [DEPTH];
    logic [DATA_WIDTH-1:0]   mem_rew  [DEPTH];
    logic [SW-1:0]           mem_ns   [DEPTH];
    logic                    mem_done [DEPTH];

    logic [SW-1:0]           ram_cs_q;
    logic [ACTION_WIDTH-1:0] ram_act_q;
    logic [DATA_WIDTH-1:0]   ram_rew_q;
    logic [SW-1:0]           ram_ns_q;
    logic                    ram_done_q;

`ifdef REPLAY_RANDOM_SAMPLE_EN
    logic [15:0]       lfsr_q, lfsr_d;
    logic [ADDR_W-1:0] cand_c;
    assign cand_c = lfsr_q[ADDR_W-1:0];

    // x^16 + x^14 + x^13 + x^11 + 1, shifting left
    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    logic unused_c;
    assign unused_c = ^{i_rd_random, LFSR_SEED};
`endif

    assign wr_en_c = i_wr_valid & rst_n;

    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem_cs[MEM_AW'(wr_ptr_q)]   <= i_current_state;
            mem_act[MEM_AW'(wr_ptr_q)]  <= i_action;
            mem_rew[MEM_AW'(wr_ptr_q)]  <= i_reward;
            mem_ns[MEM_AW'(wr_ptr_q)]   <= i_next_state;
            mem_done[MEM_AW'(wr_ptr_q)] <= i_done;
        end
    end

    // Read port fires on entry to READ; nonblocking semantics give read-first on collisions
    always_ff @(posedge clk) begin
        if (rd_en_c) begin
            ram_cs_q   <= mem_cs[MEM_AW'(rd_addr_c)];
            ram_act_q  <= mem_act[MEM_AW'(rd_addr_c)];
            ram_rew_q  <= mem_rew[MEM_AW'(rd_addr_c)];
            ram_ns_q   <= mem_ns[MEM_AW'(rd_addr_c)];
            ram_done_q <= mem_done[MEM_AW'(rd_addr_c)];
        end
    end

    // Next-state, pointer/occupancy and output logic
    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        valid_d   = 1'b0;
        rd_err_d  = 1'b0;
        cs_d      = cs_q;
        act_d     = act_q;
        rew_d     = rew_q;
        ns_d      = ns_q;
        done_d    = done_q;
        rd_en_c   = 1'b0;
        rd_addr_c = i_rd_addr;

        if (i_wr_valid) begin
            wr_ptr_d = (wr_ptr_q == LAST_A) ? '0 : wr_ptr_q + 1'b1;
            if (count_q != DEPTH_A) begin
                count_d = count_q + 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (i_rd_valid) begin
                    if (empty_q) begin
                        rd_err_d = 1'b1;
`ifdef REPLAY_RANDOM_SAMPLE_EN
                    end else if (i_rd_random) begin
                        state_d = SEARCH;
`endif
                    end else if (i_rd_addr >= count_q) begin
                        rd_err_d = 1'b1;
                    end else begin
                        state_d = READ;
                        rd_en_c = 1'b1;
                    end
                end
            end
`ifdef REPLAY_RANDOM_SAMPLE_EN
            SEARCH: begin
                if (cand_c < count_q) begin
                    state_d   = READ;
                    rd_en_c   = 1'b1;
                    rd_addr_c = cand_c;
                end
            end
`endif
            READ: begin
                state_d = IDLE;
                valid_d = 1'b1;
                cs_d    = ram_cs_q;
                act_d   = ram_act_q;
                rew_d   = ram_rew_q;
                ns_d    = ram_ns_q;
                done_d  = ram_done_q;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        full_d     = (count_d == DEPTH_A);
        empty_d    = (count_d == '0);
        rd_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            rd_ready_q <= 1'b1;
            valid_q    <= 1'b0;
            rd_err_q   <= 1'b0;
            cs_q       <= '0;
            act_q      <= '0;
            rew_q      <= '0;
            ns_q       <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            rd_ready_q <= rd_ready_d;
            valid_q    <= valid_d;
            rd_err_q   <= rd_err_d;
            cs_q       <= cs_d;
            act_q      <= act_d;
            rew_q      <= rew_d;
            ns_q       <= ns_d;
            done_q     <= done_d;
        end
    end

    assign o_rd_ready      = rd_ready_q;
    assign o_valid         = valid_q;
    assign o_rd_err        = rd_err_q;
    assign o_current_state = cs_q;
    assign o_action        = act_q;
    assign o_reward        = rew_q;
    assign o_next_state    = ns_q;
    assign o_done          = done_q;
    assign o_count         = count_q;
    assign o_full          = full_q;
    assign o_empty         = empty_q;

endmodule
